// File: rtl/bp_fe_cmd_dispatch.sv
// FE command dispatcher: queues BE commands and routes the head entry to pc_gen, itlb or icache.
// Latency: a command is presented at the head one cycle after enqueue; outputs are combinational from the head.
// Backpressure: cmd_ready_o = !full; the head is held with stable payload until its target ready is seen.
module bp_fe_cmd_dispatch #(
  parameter int vaddr_width_p               = 39,
  parameter int ppn_width_p                 = 44,
  parameter int asid_width_p                = 10,
  parameter int branch_metadata_fwd_width_p = 36,
  parameter int cmd_fifo_els_p              = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [2:0]                             cmd_opcode_i,
  input  logic [2:0]                             cmd_subopcode_i,
  input  logic [vaddr_width_p-1:0]               cmd_pc_i,
  input  logic [branch_metadata_fwd_width_p-1:0] cmd_meta_i,
  input  logic [ppn_width_p-1:0]                 cmd_ppn_i,
  input  logic [asid_width_p-1:0]                cmd_asid_i,
  input  logic                                   cmd_v_i,
  output logic                                   cmd_ready_o,
  output logic                                   pc_gen_v_o,
  input  logic                                   pc_gen_ready_i,
  output logic                                   pc_gen_redirect_o,
  output logic                                   pc_gen_mispredict_o,
  output logic                                   pc_gen_attaboy_o,
  output logic [vaddr_width_p-1:0]               pc_gen_pc_o,
  output logic [branch_metadata_fwd_width_p-1:0] pc_gen_meta_o,
  output logic                                   itlb_v_o,
  input  logic                                   itlb_ready_i,
  output logic                                   itlb_fence_o,
  output logic [vaddr_width_p-1:0]               itlb_vaddr_o,
  output logic [ppn_width_p-1:0]                 itlb_ppn_o,
  output logic [asid_width_p-1:0]                itlb_asid_o,
  input  logic                                   icache_miss_i,
  output logic                                   icache_poison_o,
  output logic                                   icache_fence_v_o,
  input  logic                                   icache_fence_ready_i,
  output logic                                   flush_o,
  output logic                                   illegal_cmd_o
);

  localparam int AW = $clog2(cmd_fifo_els_p);

  typedef enum logic [1:0] {e_ready, e_fence_wait, e_fence_issue} state_e;

  logic [2:0]                             r_op_mem   [cmd_fifo_els_p];
  logic [2:0]                             r_sub_mem  [cmd_fifo_els_p];
  logic [vaddr_width_p-1:0]               r_pc_mem   [cmd_fifo_els_p];
  logic [branch_metadata_fwd_width_p-1:0] r_meta_mem [cmd_fifo_els_p];
  logic [ppn_width_p-1:0]                 r_ppn_mem  [cmd_fifo_els_p];
  logic [asid_width_p-1:0]                r_asid_mem [cmd_fifo_els_p];

  logic [AW:0] r_wr_ptr, r_rd_ptr;
  state_e      r_state, w_state_nxt;

  logic w_full, w_empty, w_enq, w_deq;
  logic [2:0]                             w_op, w_sub;
  logic [vaddr_width_p-1:0]               w_pc;
  logic [branch_metadata_fwd_width_p-1:0] w_meta;
  logic [ppn_width_p-1:0]                 w_ppn;
  logic [asid_width_p-1:0]                w_asid;

  // Full when the wrap bits differ but the index bits match; a full FIFO never accepts.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign cmd_ready_o = !w_full;
  assign w_enq       = cmd_v_i && !w_full;

  assign w_op   = r_op_mem  [r_rd_ptr[AW-1:0]];
  assign w_sub  = r_sub_mem [r_rd_ptr[AW-1:0]];
  assign w_pc   = r_pc_mem  [r_rd_ptr[AW-1:0]];
  assign w_meta = r_meta_mem[r_rd_ptr[AW-1:0]];
  assign w_ppn  = r_ppn_mem [r_rd_ptr[AW-1:0]];
  assign w_asid = r_asid_mem[r_rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_op_mem  [r_wr_ptr[AW-1:0]] <= cmd_opcode_i;
      r_sub_mem [r_wr_ptr[AW-1:0]] <= cmd_subopcode_i;
      r_pc_mem  [r_wr_ptr[AW-1:0]] <= cmd_pc_i;
      r_meta_mem[r_wr_ptr[AW-1:0]] <= cmd_meta_i;
      r_ppn_mem [r_wr_ptr[AW-1:0]] <= cmd_ppn_i;
      r_asid_mem[r_wr_ptr[AW-1:0]] <= cmd_asid_i;
    end
  end

  // FIFO pointers; reset drops every queued command.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FSM state register; reset abandons any fence sequence in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= e_ready;
    else         r_state <= w_state_nxt;
  end

  // Next state: a fence that meets a live miss poisons it, waits for it to drain, then issues.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      e_ready:       if (!w_empty && w_op == 3'd3 && icache_miss_i) w_state_nxt = e_fence_wait;
      e_fence_wait:  if (!icache_miss_i) w_state_nxt = e_fence_issue;
      e_fence_issue: if (icache_fence_ready_i) w_state_nxt = e_ready;
      default:       w_state_nxt = e_ready;
    endcase
  end

  // Outputs and pop: exactly one target sees valid; payloads are zero when their channel is idle.
  always_comb begin
    pc_gen_v_o          = 1'b0;
    itlb_v_o            = 1'b0;
    icache_fence_v_o    = 1'b0;
    icache_poison_o     = 1'b0;
    illegal_cmd_o       = 1'b0;
    flush_o             = 1'b0;
    w_deq               = 1'b0;
    pc_gen_redirect_o   = 1'b0;
    pc_gen_mispredict_o = 1'b0;
    pc_gen_attaboy_o    = 1'b0;
    pc_gen_pc_o         = '0;
    pc_gen_meta_o       = '0;
    itlb_fence_o        = 1'b0;
    itlb_vaddr_o        = '0;
    itlb_ppn_o          = '0;
    itlb_asid_o         = '0;
    if (!w_empty) begin
      case (r_state)
        e_ready: begin
          case (w_op)
            3'd0, 3'd1, 3'd2, 3'd4: begin
              pc_gen_v_o          = 1'b1;
              w_deq               = pc_gen_ready_i;
              pc_gen_redirect_o   = (w_op != 3'd4);
              pc_gen_mispredict_o = (w_op == 3'd1) && (w_sub == 3'd4);
              pc_gen_attaboy_o    = (w_op == 3'd4);
              pc_gen_pc_o         = w_pc;
              pc_gen_meta_o       = (w_op == 3'd0 || w_op == 3'd2) ? '0 : w_meta;
              flush_o             = pc_gen_ready_i && (w_op != 3'd4);
            end
            3'd5, 3'd6: begin
              itlb_v_o     = 1'b1;
              w_deq        = itlb_ready_i;
              itlb_fence_o = (w_op == 3'd6);
              itlb_vaddr_o = w_pc;
              itlb_ppn_o   = w_ppn;
              itlb_asid_o  = w_asid;
            end
            3'd3: begin
              if (icache_miss_i) begin
                icache_poison_o = 1'b1;
              end else begin
                icache_fence_v_o = 1'b1;
                w_deq            = icache_fence_ready_i;
              end
            end
            default: begin
              illegal_cmd_o = 1'b1;
              w_deq         = 1'b1;
            end
          endcase
        end
        e_fence_issue: begin
          icache_fence_v_o = 1'b1;
          w_deq            = icache_fence_ready_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_fe_cmd_dispatch.sv
// Randomized bench: drives random commands, readies and miss activity and compares every output
// against a queue-based model of the dispatch rules each cycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_bp_fe_cmd_dispatch;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [2:0]  cmd_opcode_i, cmd_subopcode_i;
  logic [38:0] cmd_pc_i;
  logic [35:0] cmd_meta_i;
  logic [43:0] cmd_ppn_i;
  logic [9:0]  cmd_asid_i;
  logic        cmd_v_i, cmd_ready_o;
  logic        pc_gen_v_o, pc_gen_ready_i, pc_gen_redirect_o, pc_gen_mispredict_o, pc_gen_attaboy_o;
  logic [38:0] pc_gen_pc_o;
  logic [35:0] pc_gen_meta_o;
  logic        itlb_v_o, itlb_ready_i, itlb_fence_o;
  logic [38:0] itlb_vaddr_o;
  logic [43:0] itlb_ppn_o;
  logic [9:0]  itlb_asid_o;
  logic        icache_miss_i, icache_poison_o, icache_fence_v_o, icache_fence_ready_i;
  logic        flush_o, illegal_cmd_o;

  always #5 clk_i = ~clk_i;

  bp_fe_cmd_dispatch dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_opcode_i(cmd_opcode_i), .cmd_subopcode_i(cmd_subopcode_i), .cmd_pc_i(cmd_pc_i),
    .cmd_meta_i(cmd_meta_i), .cmd_ppn_i(cmd_ppn_i), .cmd_asid_i(cmd_asid_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .pc_gen_v_o(pc_gen_v_o), .pc_gen_ready_i(pc_gen_ready_i), .pc_gen_redirect_o(pc_gen_redirect_o),
    .pc_gen_mispredict_o(pc_gen_mispredict_o), .pc_gen_attaboy_o(pc_gen_attaboy_o),
    .pc_gen_pc_o(pc_gen_pc_o), .pc_gen_meta_o(pc_gen_meta_o),
    .itlb_v_o(itlb_v_o), .itlb_ready_i(itlb_ready_i), .itlb_fence_o(itlb_fence_o),
    .itlb_vaddr_o(itlb_vaddr_o), .itlb_ppn_o(itlb_ppn_o), .itlb_asid_o(itlb_asid_o),
    .icache_miss_i(icache_miss_i), .icache_poison_o(icache_poison_o),
    .icache_fence_v_o(icache_fence_v_o), .icache_fence_ready_i(icache_fence_ready_i),
    .flush_o(flush_o), .illegal_cmd_o(illegal_cmd_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  sub;
    logic [38:0] pc;
    logic [35:0] meta;
    logic [43:0] ppn;
    logic [9:0]  asid;
  } cmd_t;

  cmd_t q[$];
  // Fence progress of the head command: 0 not started, 1 miss poisoned and draining, 2 fence offered.
  int   fence_stage;
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Random knobs, changed per test phase.
  int v_pct, rdy_pct, miss_pct, rst_pct;

  initial begin
    logic [63:0] r64;
    cmd_t        h, c;
    logic        e_rdy, e_pv, e_iv, e_fv, e_poison, e_flush, e_ill, e_pop;
    logic        e_redir, e_misp, e_atta, e_ifence;
    logic [38:0] e_pc, e_vaddr;
    logic [35:0] e_meta;
    logic [43:0] e_ppn;
    logic [9:0]  e_asid;
    int          next_stage;

    reset_i = 1'b1; cmd_v_i = 1'b0; cmd_opcode_i = '0; cmd_subopcode_i = '0;
    cmd_pc_i = '0; cmd_meta_i = '0; cmd_ppn_i = '0; cmd_asid_i = '0;
    pc_gen_ready_i = 1'b0; itlb_ready_i = 1'b0; icache_miss_i = 1'b0; icache_fence_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    q.delete();
    fence_stage = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      case (cyc / 800)
        0:       begin v_pct = 80; rdy_pct = 90; miss_pct = 20; rst_pct = 0; end
        1:       begin v_pct = 90; rdy_pct = 15; miss_pct = 20; rst_pct = 0; end
        2:       begin v_pct = 60; rdy_pct = 60; miss_pct = 75; rst_pct = 0; end
        3:       begin v_pct = 95; rdy_pct = 100; miss_pct = 0; rst_pct = 0; end
        default: begin v_pct = 70; rdy_pct = 50; miss_pct = 50; rst_pct = 3; end
      endcase

      @(negedge clk_i);
      reset_i         = (cyc < 2) || ($urandom_range(99) < rst_pct);
      cmd_v_i         = ($urandom_range(99) < v_pct);
      cmd_opcode_i    = 3'($urandom_range(7));
      cmd_subopcode_i = ($urandom_range(1) == 0) ? 3'd4 : 3'($urandom_range(7));
      r64 = {$urandom, $urandom}; cmd_pc_i   = r64[38:0];
      r64 = {$urandom, $urandom}; cmd_meta_i = r64[35:0];
      r64 = {$urandom, $urandom}; cmd_ppn_i  = r64[43:0];
      cmd_asid_i           = 10'($urandom_range(1023));
      pc_gen_ready_i       = ($urandom_range(99) < rdy_pct);
      itlb_ready_i         = ($urandom_range(99) < rdy_pct);
      icache_fence_ready_i = ($urandom_range(99) < rdy_pct);
      icache_miss_i        = ($urandom_range(99) < miss_pct);
      #1;

      // Expected behaviour from the dispatch rules applied to the modelled queue head.
      e_rdy = (q.size() < DEPTH);
      {e_pv, e_iv, e_fv, e_poison, e_flush, e_ill, e_pop} = '0;
      {e_redir, e_misp, e_atta, e_ifence} = '0;
      e_pc = '0; e_meta = '0; e_vaddr = '0; e_ppn = '0; e_asid = '0;
      next_stage = fence_stage;
      if (q.size() > 0) begin
        h = q[0];
        if (fence_stage == 1) begin
          if (!icache_miss_i) next_stage = 2;
        end else if (fence_stage == 2) begin
          e_fv  = 1'b1;
          e_pop = icache_fence_ready_i;
          if (e_pop) next_stage = 0;
        end else if (h.op == 3'd0 || h.op == 3'd1 || h.op == 3'd2 || h.op == 3'd4) begin
          e_pv    = 1'b1;
          e_pop   = pc_gen_ready_i;
          e_redir = (h.op <= 3'd2);
          e_misp  = (h.op == 3'd1) && (h.sub == 3'd4);
          e_atta  = (h.op == 3'd4);
          e_pc    = h.pc;
          e_meta  = (h.op == 3'd1 || h.op == 3'd4) ? h.meta : 36'd0;
          e_flush = e_pop && e_redir;
        end else if (h.op == 3'd5 || h.op == 3'd6) begin
          e_iv     = 1'b1;
          e_pop    = itlb_ready_i;
          e_ifence = (h.op == 3'd6);
          e_vaddr  = h.pc;
          e_ppn    = h.ppn;
          e_asid   = h.asid;
        end else if (h.op == 3'd7) begin
          e_ill = 1'b1;
          e_pop = 1'b1;
        end else if (icache_miss_i) begin
          e_poison   = 1'b1;
          next_stage = 1;
        end else begin
          e_fv  = 1'b1;
          e_pop = icache_fence_ready_i;
        end
      end

      check("cmd_ready", 64'(cmd_ready_o), 64'(e_rdy));
      check("pc_gen_v", 64'(pc_gen_v_o), 64'(e_pv));
      check("itlb_v", 64'(itlb_v_o), 64'(e_iv));
      check("icache_fence_v", 64'(icache_fence_v_o), 64'(e_fv));
      check("poison", 64'(icache_poison_o), 64'(e_poison));
      check("flush", 64'(flush_o), 64'(e_flush));
      check("illegal", 64'(illegal_cmd_o), 64'(e_ill));
      if (e_pv) begin
        check("pc_gen_flags", 64'({pc_gen_redirect_o, pc_gen_mispredict_o, pc_gen_attaboy_o}),
              64'({e_redir, e_misp, e_atta}));
        check("pc_gen_pc", 64'(pc_gen_pc_o), 64'(e_pc));
        check("pc_gen_meta", 64'(pc_gen_meta_o), 64'(e_meta));
      end
      if (e_iv) begin
        check("itlb_fence", 64'(itlb_fence_o), 64'(e_ifence));
        check("itlb_vaddr", 64'(itlb_vaddr_o), 64'(e_vaddr));
        check("itlb_ppn", 64'(itlb_ppn_o), 64'(e_ppn));
        check("itlb_asid", 64'(itlb_asid_o), 64'(e_asid));
      end

      // Advance the model at the rising edge using the same sampled inputs.
      @(posedge clk_i);
      if (reset_i) begin
        q.delete();
        fence_stage = 0;
      end else begin
        if (e_pop) void'(q.pop_front());
        if (cmd_v_i && e_rdy) begin
          c.op = cmd_opcode_i; c.sub = cmd_subopcode_i; c.pc = cmd_pc_i;
          c.meta = cmd_meta_i; c.ppn = cmd_ppn_i; c.asid = cmd_asid_i;
          q.push_back(c);
        end
        fence_stage = next_stage;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_fe_cmd_dispatch.md
Name: bp_fe_cmd_dispatch

Overview:
- Front-end command dispatcher between the BE command channel and the FE sub-units (pc_gen, itlb, icache).
- Buffers BE commands in a parametrised FIFO and decodes the head entry.
- Routes each command to exactly one target channel with valid/ready handshakes.
- Sequences icache fences against an outstanding miss: poison the miss, wait for it to retire, then issue the fence.

Parameters:
- vaddr_width_p, 39, virtual PC width
- ppn_width_p, 44, physical page number width for itlb fill
- asid_width_p, 10, address-space id width
- branch_metadata_fwd_width_p, 36, opaque branch metadata width
- cmd_fifo_els_p, 4, command FIFO depth; must be a power of 2 and ≥2

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cmd_opcode_i  in  3  0 state_reset, 1 pc_redirect, 2 interrupt, 3 icache_fence, 4 attaboy, 5 itlb_fill, 6 itlb_fence, 7 illegal
- cmd_subopcode_i  in  3  redirect subopcode; 4 = branch_mispredict
- cmd_pc_i  in  vaddr_width_p  target/attaboy PC or fill vaddr
- cmd_meta_i  in  branch_metadata_fwd_width_p  branch metadata
- cmd_ppn_i  in  ppn_width_p  itlb fill PPN
- cmd_asid_i  in  asid_width_p  ASID
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  FIFO not full
- pc_gen_v_o  out  1  pc_gen command valid
- pc_gen_ready_i  in  1  pc_gen accepts
- pc_gen_redirect_o  out  1  opcode ∈ {0,1,2}
- pc_gen_mispredict_o  out  1  opcode==1 and subopcode==4
- pc_gen_attaboy_o  out  1  opcode==4
- pc_gen_pc_o  out  vaddr_width_p  head PC
- pc_gen_meta_o  out  branch_metadata_fwd_width_p  head metadata; 0 for opcodes 0 and 2
- itlb_v_o  out  1  itlb command valid
- itlb_ready_i  in  1  itlb accepts
- itlb_fence_o  out  1  1 = fence, 0 = fill
- itlb_vaddr_o  out  vaddr_width_p  fill vaddr
- itlb_ppn_o  out  ppn_width_p  fill PPN
- itlb_asid_o  out  asid_width_p  ASID
- icache_miss_i  in  1  icache has a miss in flight
- icache_poison_o  out  1  one-cycle poison of the in-flight miss
- icache_fence_v_o  out  1  icache fence valid
- icache_fence_ready_i  in  1  icache accepts fence
- flush_o  out  1  one-cycle flush of in-flight fetch
- illegal_cmd_o  out  1  one-cycle pulse when an opcode-7 command is dropped

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; rd/wr pointers = 0.
  - FSM = e_ready.
  - All *_v_o, icache_poison_o, flush_o and illegal_cmd_o = 0.
  - cmd_ready_o = 1 in the cycle after reset deasserts.
- Reset mid-operation discards all queued commands and any fence in progress.
- FIFO:
  - Enqueue on cmd_v_i & cmd_ready_o.
  - cmd_ready_o = !full. When full, no enqueue even if a dequeue happens in the same cycle.
  - Pointers are log2(cmd_fifo_els_p)+1 bits and wrap naturally; full/empty are derived from the MSB compare.
  - No bypass: a command enqueued in cycle N is earliest presented at the head in cycle N+1.
  - Simultaneous enqueue and dequeue when neither full nor empty keeps the count unchanged.
- Outputs are driven combinationally from the registered head entry and the FSM. Only one *_v_o is asserted per cycle.
- Dispatch from the head, FSM state e_ready, FIFO non-empty:
  - Opcodes 0, 1, 2, 4:
    - Drive pc_gen_v_o.
    - Pop on pc_gen_ready_i.
    - On that handshake with opcode ∈ {0,1,2}, flush_o = 1 for exactly that cycle.
  - Opcodes 5, 6:
    - Drive itlb_v_o.
    - itlb_fence_o = (opcode==6).
    - Pop on itlb_ready_i.
  - Opcode 7:
    - Popped in one cycle with no target valid.
    - illegal_cmd_o = 1 that cycle.
  - Opcode 3 with icache_miss_i=0:
    - Drive icache_fence_v_o.
    - Pop on icache_fence_ready_i.
  - Opcode 3 with icache_miss_i=1:
    - icache_poison_o = 1 this cycle; no valid asserted.
    - Next state e_fence_wait.
- e_fence_wait:
  - All valids low and poison low while icache_miss_i=1.
  - When icache_miss_i=0, next state e_fence_issue.
- e_fence_issue:
  - icache_fence_v_o = 1.
  - icache_miss_i is ignored in this state; no re-poison.
  - On icache_fence_ready_i: pop and return to e_ready.
- Valid stays asserted with stable payload until the corresponding ready is seen (no retraction).
- Throughput: one dispatch per cycle when targets are always ready.

Test Plan:
- Reset, then 4 back-to-back attaboys (pc 0x100..0x10C) with pc_gen_ready_i=1:
  - cmd_ready_o stays 1.
  - pc_gen_v_o high cycles 1-4 with pc 0x100, 0x104, 0x108, 0x10C.
  - pc_gen_attaboy_o=1, flush_o=0.
- Hold pc_gen_ready_i=0 and push 5 redirects (depth 4):
  - cmd_ready_o drops after the 4th push.
  - 5th command is held by the source.
  - Release ready: 4 pops in order, each with flush_o pulse.
  - cmd_ready_o reasserts the cycle after the first pop.
- Redirect with subopcode 4, meta 0xABC:
  - pc_gen_mispredict_o=1, pc_gen_meta_o=0xABC, flush_o=1 on the handshake cycle only.
- icache_fence with icache_miss_i=1 for 3 cycles:
  - icache_poison_o=1 exactly one cycle.
  - No valids for 3 cycles.
  - icache_fence_v_o=1 the cycle after miss falls.
  - Pop on ready.
- itlb_fill (ppn 0x123, asid 5), then opcode 7, then itlb_fence, itlb_ready_i=1:
  - itlb_v_o with fence_o=0, ppn 0x123.
  - Next cycle illegal_cmd_o=1.
  - Next cycle itlb_v_o with fence_o=1.
- Assert reset_i while in e_fence_wait with 3 queued commands:
  - Next cycle FIFO empty, all outputs 0.
  - Post-reset command dispatches normally.
